// File: rtl/gfx_perspective_divide.sv
// gfx_perspective_divide: projects a transformed point to screen space by
// computing x/z and y/z in signed fixed point with a bit-serial restoring
// divider. Both quotients share the divisor |z| and run in lockstep, so the
// latency is fixed. Results saturate on overflow and on division by zero.
//
// Handshake: start_i is sampled only while IDLE (busy_o low). A request made
// while busy_o is high is dropped, not queued. ack_o pulses for one cycle when
// the results are registered, and x_o/y_o/point_id_o/sat_o hold until the
// next ack. z_o is latched when the request is accepted.
module gfx_perspective_divide #(
    parameter int POINT_WIDTH    = 16,
    parameter int SUBPIXEL_WIDTH = 16
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [POINT_WIDTH+SUBPIXEL_WIDTH-1:0] x_i,
    input  logic [POINT_WIDTH+SUBPIXEL_WIDTH-1:0] y_i,
    input  logic [POINT_WIDTH+SUBPIXEL_WIDTH-1:0] z_i,
    input  logic [1:0]                            point_id_i,
    input  logic                                  start_i,
    output logic                                  busy_o,
    output logic [POINT_WIDTH+SUBPIXEL_WIDTH-1:0] x_o,
    output logic [POINT_WIDTH+SUBPIXEL_WIDTH-1:0] y_o,
    output logic [POINT_WIDTH-1:0]                z_o,
    output logic [1:0]                            point_id_o,
    output logic                                  sat_o,
    output logic                                  ack_o,
    output logic [1:0]                            dbg_state_o
);

    localparam int W  = POINT_WIDTH + SUBPIXEL_WIDTH;
    localparam int N  = W + SUBPIXEL_WIDTH;
    localparam int CW = $clog2(N);

    // Quotient limits, expressed in the N-bit quotient domain
    localparam logic [N-1:0] POS_LIM = {{(N-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic [N-1:0] NEG_LIM = {{(N-W){1'b0}}, 1'b1, {(W-1){1'b0}}};
    // Saturated output codes
    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic                sign_x_q, sign_x_d;
    logic                sign_y_q, sign_y_d;
    logic                sign_z_q, sign_z_d;
    logic [W:0]          mag_x_q, mag_x_d;
    logic [W:0]          mag_y_q, mag_y_d;
    logic [W:0]          mag_z_q, mag_z_d;
    logic                zdiv_q, zdiv_d;
    logic [CW-1:0]       count_q, count_d;
    logic [W:0]          rem_x_q, rem_x_d;
    logic [W:0]          rem_y_q, rem_y_d;
    logic [N-1:0]        quo_x_q, quo_x_d;
    logic [N-1:0]        quo_y_q, quo_y_d;
    logic [1:0]          id_q, id_d;
    logic [W-1:0]        x_out_q, x_out_d;
    logic [W-1:0]        y_out_q, y_out_d;
    logic [POINT_WIDTH-1:0] z_out_q, z_out_d;
    logic [1:0]          id_out_q, id_out_d;
    logic                sat_q, sat_d;
    logic                ack_q, ack_d;

    // Magnitude in W+1 bits so that |-2^(W-1)| is representable
    function automatic logic [W:0] magnitude(input logic [W-1:0] v);
        logic [W:0] ext;
        ext = {v[W-1], v};
        return v[W-1] ? (~ext + 1'b1) : ext;
    endfunction

    // One restoring step: returns {quotient_bit, new_remainder}
    function automatic logic [W+1:0] div_step(input logic [W:0] rem,
                                              input logic       nbit,
                                              input logic [W:0] d);
        logic [W+1:0] sh;
        logic [W:0]   diff;
        sh   = {rem, nbit};
        diff = sh[W:0] - d;
        if (sh >= {1'b0, d}) begin
            return {1'b1, diff};
        end
        return {1'b0, sh[W:0]};
    endfunction

    // Apply the result sign and saturate: returns {sat, value}
    function automatic logic [W:0] sat_result(input logic [N-1:0] q,
                                              input logic         neg);
        logic [W-1:0] low;
        low = q[W-1:0];
        if (!neg) begin
            if (q > POS_LIM) begin
                return {1'b1, MAX_POS};
            end
            return {1'b0, low};
        end
        if (q > NEG_LIM) begin
            return {1'b1, MIN_NEG};
        end
        return {1'b0, ~low + 1'b1};
    endfunction

    logic [CW-1:0] bit_idx;
    logic          nbit_x, nbit_y;
    logic [W+1:0]  step_x, step_y;
    logic [W:0]    res_x, res_y;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sign_x_q <= 1'b0;
            sign_y_q <= 1'b0;
            sign_z_q <= 1'b0;
            mag_x_q  <= '0;
            mag_y_q  <= '0;
            mag_z_q  <= '0;
            zdiv_q   <= 1'b0;
            count_q  <= '0;
            rem_x_q  <= '0;
            rem_y_q  <= '0;
            quo_x_q  <= '0;
            quo_y_q  <= '0;
            id_q     <= '0;
            x_out_q  <= '0;
            y_out_q  <= '0;
            z_out_q  <= '0;
            id_out_q <= '0;
            sat_q    <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            sign_x_q <= sign_x_d;
            sign_y_q <= sign_y_d;
            sign_z_q <= sign_z_d;
            mag_x_q  <= mag_x_d;
            mag_y_q  <= mag_y_d;
            mag_z_q  <= mag_z_d;
            zdiv_q   <= zdiv_d;
            count_q  <= count_d;
            rem_x_q  <= rem_x_d;
            rem_y_q  <= rem_y_d;
            quo_x_q  <= quo_x_d;
            quo_y_q  <= quo_y_d;
            id_q     <= id_d;
            x_out_q  <= x_out_d;
            y_out_q  <= y_out_d;
            z_out_q  <= z_out_d;
            id_out_q <= id_out_d;
            sat_q    <= sat_d;
            ack_q    <= ack_d;
        end
    end

    // Next-state, divider step and result formatting
    always_comb begin
        state_d  = state_q;
        sign_x_d = sign_x_q;
        sign_y_d = sign_y_q;
        sign_z_d = sign_z_q;
        mag_x_d  = mag_x_q;
        mag_y_d  = mag_y_q;
        mag_z_d  = mag_z_q;
        zdiv_d   = zdiv_q;
        count_d  = count_q;
        rem_x_d  = rem_x_q;
        rem_y_d  = rem_y_q;
        quo_x_d  = quo_x_q;
        quo_y_d  = quo_y_q;
        id_d     = id_q;
        x_out_d  = x_out_q;
        y_out_d  = y_out_q;
        z_out_d  = z_out_q;
        id_out_d = id_out_q;
        sat_d    = sat_q;
        ack_d    = 1'b0;
        bit_idx  = '0;
        nbit_x   = 1'b0;
        nbit_y   = 1'b0;
        step_x   = '0;
        step_y   = '0;
        res_x    = '0;
        res_y    = '0;

        // Numerator is |v| << SUBPIXEL_WIDTH; low bits are always zero
        if (count_q >= CW'(SUBPIXEL_WIDTH)) begin
            bit_idx = count_q - CW'(SUBPIXEL_WIDTH);
            nbit_x  = mag_x_q[bit_idx];
            nbit_y  = mag_y_q[bit_idx];
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    sign_x_d = x_i[W-1];
                    sign_y_d = y_i[W-1];
                    sign_z_d = z_i[W-1];
                    mag_x_d  = magnitude(x_i);
                    mag_y_d  = magnitude(y_i);
                    mag_z_d  = magnitude(z_i);
                    zdiv_d   = (z_i == '0);
                    z_out_d  = z_i[W-1:SUBPIXEL_WIDTH];
                    id_d     = point_id_i;
                    rem_x_d  = '0;
                    rem_y_d  = '0;
                    quo_x_d  = '0;
                    quo_y_d  = '0;
                    count_d  = CW'(N-1);
                    state_d  = (z_i == '0) ? S_DONE : S_DIV;
                end
            end
            S_DIV: begin
                step_x  = div_step(rem_x_q, nbit_x, mag_z_q);
                step_y  = div_step(rem_y_q, nbit_y, mag_z_q);
                rem_x_d = step_x[W:0];
                rem_y_d = step_y[W:0];
                quo_x_d = {quo_x_q[N-2:0], step_x[W+1]};
                quo_y_d = {quo_y_q[N-2:0], step_y[W+1]};
                if (count_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            S_DONE: begin
                if (zdiv_q) begin
                    // Divide by zero: sign of the numerator picks the rail
                    if (mag_x_q == '0) begin
                        res_x = {1'b1, {W{1'b0}}};
                    end else begin
                        res_x = {1'b1, sign_x_q ? MIN_NEG : MAX_POS};
                    end
                    if (mag_y_q == '0) begin
                        res_y = {1'b1, {W{1'b0}}};
                    end else begin
                        res_y = {1'b1, sign_y_q ? MIN_NEG : MAX_POS};
                    end
                end else begin
                    res_x = sat_result(quo_x_q, sign_x_q ^ sign_z_q);
                    res_y = sat_result(quo_y_q, sign_y_q ^ sign_z_q);
                end
                x_out_d  = res_x[W-1:0];
                y_out_d  = res_y[W-1:0];
                sat_d    = res_x[W] | res_y[W] | zdiv_q;
                id_out_d = id_q;
                ack_d    = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o      = (state_q != S_IDLE);
    assign x_o         = x_out_q;
    assign y_o         = y_out_q;
    assign z_o         = z_out_q;
    assign point_id_o  = id_out_q;
    assign sat_o       = sat_q;
    assign ack_o       = ack_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/gfx_perspective_divide.md
# gfx_perspective_divide

Projection stage that sits directly downstream of the point transform in the orgfx pipeline. It takes one transformed point (signed 16.16 x, y, z), computes the perspective-projected screen coordinates x/z and y/z in 16.16 fixed point, and returns them with the originating point id. Division is a bit-serial restoring divider: x and y are divided in parallel against a shared divisor |z|, giving deterministic latency. Results saturate on overflow and on division by zero.

## Interface
- point_width, 16, integer bits of every coordinate
- subpixel_width, 16, fractional bits of every coordinate
- clk_i  in  1  clock; all logic on rising edge
- rst_ni  in  1  reset, asynchronous and active-low
- x_i, y_i, z_i  in  point_width+subpixel_width  signed fixed-point input point
- point_id_i  in  2  point index (0, 1 or 2), carried through
- start_i  in  1  request; sampled only in IDLE
- busy_o  out  1  high in DIV and DONE
- x_o, y_o  out  point_width+subpixel_width  signed projected result
- z_o  out  point_width  integer part of z_i, z_i[point_width+subpixel_width-1:subpixel_width], latched at start
- point_id_o  out  2  latched point_id_i
- sat_o  out  1  result saturated (z==0 or overflow); valid with ack_o
- ack_o  out  1  one-cycle pulse; outputs valid from this cycle until the next ack

## Operation
- Let W = point_width+subpixel_width (32), N = W+subpixel_width (48).
- The state machine has three states: IDLE, DIV, DONE. The reset state is IDLE.
- IDLE: ack_o is driven to 0. On start_i:
  - latch sign(x), sign(y), |x|, |y|, |z|, z integer part and point_id.
  - If z_i==0, go to DONE. Otherwise load count=N-1 and go to DIV.
- DIV:
  - Each cycle, shift one bit of numerator |x|<<subpixel_width (N bits) into each partial remainder, MSB first.
  - Restoring step: if remainder >= |z|, subtract |z| and shift in quotient bit 1; otherwise shift in 0.
  - x and y share the same divisor.
  - When count==0, go to DONE; otherwise decrement count.
- DONE: register the outputs, pulse ack_o=1 and return to IDLE. Per component:
  - Quotient magnitude q is N bits; rounding is truncation toward zero.
  - Positive result: if q > 2^(W-1)-1, output 2^(W-1)-1 and set sat. Otherwise output q.
  - Negative result: if q > 2^(W-1), output -2^(W-1) and set sat. Otherwise output -q (two's complement).
  - z==0 case: numerator >0 gives max positive, <0 gives most negative, ==0 gives 0. sat_o=1 in all three.
  - sat_o = sat_x OR sat_y OR (z==0).
  - The result sign is sign(numerator) XOR sign(z).
  - Magnitudes are computed in W+1 bits so that |-2^(W-1)| is exact.
- start_i in DIV or DONE is ignored; there is no queueing. The upstream stage holds start_i until it sees busy_o low.

## Timing
- Reset values: x_o, y_o, z_o, point_id_o = 0; sat_o, ack_o, busy_o = 0; state = IDLE.
- Reset mid-operation (DIV or DONE) aborts immediately. All outputs return to their reset values and no ack is produced.
- Latency with z!=0:
  - the edge sampling start_i is edge 0;
  - DIV occupies edges 1..N;
  - DONE at edge N+1 asserts ack_o, high for exactly one cycle.
  - Total is 49 edges at default parameters.
- Latency with z==0: ack_o follows 1 edge after sampling.
- busy_o rises on the edge after start_i is sampled and falls on the same edge that raises ack_o.
- Back-to-back operation: start_i may be sampled the cycle ack_o is high (state is IDLE). Throughput is one point per N+2 cycles.
- Outputs hold their value between acks.

## Test plan
- Basic divide: x=0x0002_0000, y=0x0003_0000, z=0x0002_0000, id=1 -> ack_o 49 edges after start. Required outputs: x_o=0x0001_0000, y_o=0x0001_8000, z_o=2, point_id_o=1, sat_o=0.
- Signs and truncation: x=0xFFFF_0000 (-1.0), y=0x0001_0000, z=0x0003_0000 -> x_o=0xFFFF_AAAB, y_o=0x0000_5555, sat_o=0. Negating z gives the opposite signs.
- Divide by zero: z=0, x=0x0001_0000, y=0xFFFF_0000 -> ack 1 edge after start. Required outputs: x_o=0x7FFF_FFFF, y_o=0x8000_0000, sat_o=1. Repeat with x=0, expect x_o=0.
- Overflow: x=0x7FFF_0000, y=0x8000_0000, z=0x0000_0100 -> x_o=0x7FFF_FFFF, y_o=0x8000_0000, sat_o=1. Exact edge case: x=0x8000_0000, z=0x0001_0000 -> x_o=0x8000_0000, sat_o=0.
- Handshake: pulse start_i again at edge 10 of an operation -> ignored, one ack only, results from the first request. Start on the ack cycle -> accepted, second ack 49 edges later.
- Reset mid-op: assert rst_ni low at edge 20 for one cycle -> all outputs 0 asynchronously, no ack. A fresh start then completes normally.
